// File: rtl/cnn_pkg.sv
// Constants and types shared by the CNN pixel-input interface blocks.
package cnn_pkg;

  localparam int PIX_W   = 8;
  localparam int CLASS_W = 4;
  localparam int SCORE_W = 32;
  localparam logic [CLASS_W-1:0] CLASS_TIMEOUT = 4'hF;

  localparam int DEF_IMG_W  = 28;
  localparam int DEF_IMG_H  = 28;
  localparam int IMG_PIXELS = DEF_IMG_W * DEF_IMG_H;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_GAP      = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_WAIT_RES = 3'd4,
    ST_DONE     = 3'd5
  } tx_state_t;

  // Bits needed to hold every value in 0..max_val, never fewer than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pixel_frame_ram.sv
// Single-clock simple dual-port frame buffer; a colliding read returns the old word.
module pixel_frame_ram #(
  parameter int DEPTH = 784,
  parameter int AW    = 10,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// Streams a buffered frame into the inference core with per-pixel idle gaps and
// a zero flush, then latches the core's classification result or times out.
module pixel_stream_tx
  import cnn_pkg::*;
#(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int GAP_CYCLES  = 50,
  parameter int FLUSH_LEN   = 100,
  parameter int TIMEOUT_CYC = 500000,
  parameter int ADDR_W      = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ld_en,
  input  logic [ADDR_W-1:0]         ld_addr,
  input  logic [PIX_W-1:0]          ld_data,
  input  logic                      start,
  output logic                      busy,
  output logic                      out_valid,
  output logic [PIX_W-1:0]          out_data,
  input  logic                      class_valid_in,
  input  logic [CLASS_W-1:0]        class_in,
  input  logic signed [SCORE_W-1:0] class_value_in,
  output logic                      done,
  output logic                      timeout,
  output logic [CLASS_W-1:0]        res_class,
  output logic signed [SCORE_W-1:0] res_value
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int IDX_W = cnt_width(NPIX - 1);
  localparam int GAP_W = cnt_width(GAP_CYCLES);
  localparam int FL_W  = cnt_width(FLUSH_LEN);
  localparam int TO_W  = cnt_width(TIMEOUT_CYC);
  localparam tx_state_t AFTER_PIX = (FLUSH_LEN > 0) ? ST_FLUSH : ST_WAIT_RES;

  tx_state_t        state_reg, state_next;
  logic [IDX_W-1:0] pix_idx_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [FL_W-1:0]  flush_cnt_reg;
  logic [TO_W-1:0]  to_cnt_reg;
  logic             captured_reg;
  logic             send_sel_reg;
  logic             valid_next, send_next, busy_next, done_next;
  logic [IDX_W-1:0] rd_addr;
  logic [PIX_W-1:0] rd_data;

  logic accept, in_xfer, cap_now, last_pix, gap_end, flush_end, to_end, timeout_hit, wr_ok;

  assign accept      = (state_reg == ST_IDLE) && start;
  assign in_xfer     = state_reg inside {ST_SEND, ST_GAP, ST_FLUSH, ST_WAIT_RES};
  assign cap_now     = in_xfer && class_valid_in && !captured_reg;
  assign last_pix    = int'(pix_idx_reg) == NPIX - 1;
  assign gap_end     = int'(gap_cnt_reg) == GAP_CYCLES - 1;
  assign flush_end   = int'(flush_cnt_reg) == FLUSH_LEN - 1;
  assign to_end      = int'(to_cnt_reg) == TIMEOUT_CYC - 1;
  assign timeout_hit = (state_reg == ST_WAIT_RES) && to_end && !cap_now && !captured_reg;
  assign wr_ok       = ld_en && (int'(ld_addr) < NPIX);

  // Address runs one pixel ahead so the synchronous read lands on the SEND cycle.
  assign rd_addr  = (state_reg == ST_IDLE || last_pix) ? '0 : pix_idx_reg + IDX_W'(1);
  assign out_data = send_sel_reg ? rd_data : '0;

  pixel_frame_ram #(
    .DEPTH (NPIX),
    .AW    (IDX_W),
    .DW    (PIX_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (ld_addr[IDX_W-1:0]),
    .wr_data (ld_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      pix_idx_reg   <= '0;
      gap_cnt_reg   <= '0;
      flush_cnt_reg <= '0;
      to_cnt_reg    <= '0;
      captured_reg  <= 1'b0;
      send_sel_reg  <= 1'b0;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      res_class     <= '0;
      res_value     <= '0;
    end else begin
      state_reg    <= state_next;
      out_valid    <= valid_next;
      send_sel_reg <= send_next;
      busy         <= busy_next;
      done         <= done_next;
      if (accept) begin
        pix_idx_reg   <= '0;
        gap_cnt_reg   <= '0;
        flush_cnt_reg <= '0;
        to_cnt_reg    <= '0;
        timeout       <= 1'b0;
        captured_reg  <= 1'b0;
      end else begin
        if (state_next == ST_SEND) pix_idx_reg <= pix_idx_reg + IDX_W'(1);
        if (state_reg == ST_GAP) gap_cnt_reg <= gap_end ? '0 : gap_cnt_reg + GAP_W'(1);
        if (state_reg == ST_FLUSH) flush_cnt_reg <= flush_end ? '0 : flush_cnt_reg + FL_W'(1);
        if (state_reg == ST_WAIT_RES) to_cnt_reg <= to_cnt_reg + TO_W'(1);
        if (cap_now) begin
          captured_reg <= 1'b1;
          res_class    <= class_in;
          res_value    <= class_value_in;
        end
        if (timeout_hit) begin
          timeout   <= 1'b1;
          res_class <= CLASS_TIMEOUT;
          res_value <= '0;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:     if (start) state_next = ST_SEND;
      ST_SEND: begin
        if (GAP_CYCLES > 0) state_next = ST_GAP;
        else                state_next = last_pix ? AFTER_PIX : ST_SEND;
      end
      ST_GAP:      if (gap_end) state_next = last_pix ? AFTER_PIX : ST_SEND;
      ST_FLUSH:    if (flush_end) state_next = ST_WAIT_RES;
      ST_WAIT_RES: if (cap_now || captured_reg || to_end) state_next = ST_DONE;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_next = (state_next == ST_SEND) || (state_next == ST_FLUSH);
    send_next  = (state_next == ST_SEND);
    busy_next  = state_next inside {ST_SEND, ST_GAP, ST_FLUSH, ST_WAIT_RES};
    done_next  = (state_next == ST_DONE);
  end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed bench for pixel_stream_tx: a frame-level reference model checked every
// cycle, plus literal expectations for latencies, beat values and result capture.
module tb_pixel_stream_tx;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int GAP  = 2;
  localparam int FL   = 3;
  localparam int TO   = 20;
  localparam int AW   = 5;
  localparam int NPIX = W * H;
  localparam int P    = 1 + GAP;

  logic               clk, rst_n;
  logic               ld_en, start, start_b, cv, cv_b;
  logic [AW-1:0]      ld_addr;
  logic [7:0]         ld_data;
  logic [3:0]         cls;
  logic signed [31:0] cval;
  logic               busy, out_valid, done, timeout;
  logic [7:0]         out_data;
  logic [3:0]         res_class;
  logic signed [31:0] res_value;
  logic               busy_b, valid_b, done_b, timeout_b;
  logic [7:0]         data_b;
  logic [3:0]         res_class_b;
  logic signed [31:0] res_value_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 0;
  bit mon_en = 0;

  pixel_stream_tx #(
    .IMG_W(W), .IMG_H(H), .GAP_CYCLES(GAP), .FLUSH_LEN(FL), .TIMEOUT_CYC(TO), .ADDR_W(AW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .busy(busy), .out_valid(out_valid), .out_data(out_data),
    .class_valid_in(cv), .class_in(cls), .class_value_in(cval),
    .done(done), .timeout(timeout), .res_class(res_class), .res_value(res_value)
  );

  pixel_stream_tx #(
    .IMG_W(W), .IMG_H(H), .GAP_CYCLES(0), .FLUSH_LEN(FL), .TIMEOUT_CYC(TO), .ADDR_W(AW)
  ) u_b2b (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start_b), .busy(busy_b), .out_valid(valid_b), .out_data(data_b),
    .class_valid_in(cv_b), .class_in(cls), .class_value_in(cval),
    .done(done_b), .timeout(timeout_b), .res_class(res_class_b), .res_value(res_value_b)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (frame-level rules) ----------------
  logic [7:0]  fb_model [NPIX];
  bit          m_active;
  int          m_k, m_cap_k;
  logic        e_valid, e_busy, e_done, e_to;
  logic [7:0]  e_data;
  logic [3:0]  e_cls;
  logic [31:0] e_val;

  // Cycle index (1 = first beat) at which done pulses, given the capture cycle.
  function automatic int done_of(input int cap);
    int wk;
    wk = 1 + NPIX * P + FL;
    if (cap < 0)  return wk + TO;
    if (cap < wk) return wk + 1;
    return cap + 1;
  endfunction

  initial begin
    m_active = 0; m_k = 0; m_cap_k = -1;
    e_valid = 0; e_busy = 0; e_done = 0; e_to = 0; e_data = 0; e_cls = 0; e_val = 0;
    for (int i = 0; i < NPIX; i++) fb_model[i] = 8'h00;
  end

  always @(negedge clk) begin
    int dk;
    if (!rst_n) begin
      m_active = 0; m_k = 0; m_cap_k = -1;
      e_valid = 0; e_busy = 0; e_done = 0; e_to = 0; e_data = 0; e_cls = 0; e_val = 0;
    end
    if (chk_en) begin
      chk("valid", 32'(out_valid), 32'(e_valid));
      chk("data", 32'(out_data), 32'(e_data));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("timeout", 32'(timeout), 32'(e_to));
      chk("res_class", 32'(res_class), 32'(e_cls));
      chk("res_value", res_value, e_val);
    end
    if (rst_n) begin
      if (m_active) begin
        if (m_k == done_of(m_cap_k)) begin
          m_active = 0;
        end else begin
          if (cv && m_cap_k < 0) begin
            m_cap_k = m_k; e_cls = cls; e_val = cval;
          end
          m_k++;
          if (m_cap_k < 0 && m_k == done_of(m_cap_k)) begin
            e_to = 1; e_cls = 4'hF; e_val = 0;
          end
        end
      end else if (start) begin
        m_active = 1; m_k = 1; m_cap_k = -1; e_to = 0;
      end
      e_valid = 0; e_data = 0; e_busy = 0; e_done = 0;
      if (m_active) begin
        dk = done_of(m_cap_k);
        e_busy = (m_k < dk);
        e_done = (m_k == dk);
        if (m_k <= NPIX * P) begin
          e_valid = ((m_k - 1) % P) == 0;
          if (e_valid) e_data = fb_model[(m_k - 1) / P];
        end else if (m_k <= NPIX * P + FL) begin
          e_valid = 1;
        end
      end
    end
    if (ld_en && int'(ld_addr) < NPIX) fb_model[ld_addr[3:0]] = ld_data;
  end

  // ---------------- monitor ----------------
  int         first_cyc, done_cyc;
  logic       busy_at_done;
  logic [7:0] beats [$];

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        beats.push_back(out_data);
      end
      if (done) begin
        done_cyc = cyc;
        busy_at_done = busy;
      end
    end
  end

  task automatic mon_clear();
    first_cyc = -1; done_cyc = -1; busy_at_done = 1'b1; beats.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input int a, input int d);
    ld_en = 1; ld_addr = a[AW-1:0]; ld_data = d[7:0];
    tick();
    ld_en = 0;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cyc < 0; i++) tick();
    n_cmp++;
    if (done_cyc < 0) begin
      n_err++;
      $display("FAIL wait_done: no done pulse within %0d cycles", budget);
    end
  endtask

  initial begin
    rst_n = 0; ld_en = 0; ld_addr = 0; ld_data = 0; start = 0; start_b = 0;
    cv = 0; cv_b = 0; cls = 0; cval = 0;
    mon_clear();
    tick(); tick();
    chk_en = 1;
    tick();
    chk("reset busy", 32'(busy), 0);
    chk("reset valid", 32'(out_valid), 0);
    chk("reset res_class", 32'(res_class), 0);
    chk("reset timeout", 32'(timeout), 0);
    rst_n = 1;
    tick();

    for (int i = 0; i < NPIX; i++) load(i, i + 1);
    load(16, 8'hAA);
    mon_en = 1;

    // Basic stream, result injected 5 cycles into WAIT_RES.
    mon_clear(); pulse_start();
    repeat (56) tick();
    cv = 1; cls = 4'd7; cval = -42; tick(); cv = 0;
    wait_done(100);
    chk("basic latency", 32'(done_cyc - first_cyc), 57);
    chk("basic beat count", 32'(beats.size()), 19);
    chk("basic pixel0", 32'(beats[0]), 1);
    chk("basic pixel15", 32'(beats[15]), 16);
    chk("basic flush beat", 32'(beats[18]), 0);
    chk("basic busy at done", 32'(busy_at_done), 0);
    chk("basic res_class", 32'(res_class), 7);
    chk("basic res_value", res_value, 32'hFFFF_FFD6);

    // Back-to-back instance: 16 pixels then 3 flush beats, no idle in between.
    start_b = 1; tick(); start_b = 0;
    for (int k = 1; k <= NPIX + FL; k++) begin
      chk("b2b valid", 32'(valid_b), 1);
      chk("b2b data", 32'(data_b), (k <= NPIX) ? k : 0);
      tick();
    end
    chk("b2b stream end", 32'(valid_b), 0);

    // Early result during pixel 10, then a second one that must be ignored.
    mon_clear(); pulse_start();
    repeat (30) tick();
    cv = 1; cls = 4'd3; cval = 100; tick(); cv = 0;
    repeat (4) tick();
    cv = 1; cls = 4'd5; cval = 555; tick(); cv = 0;
    wait_done(100);
    chk("early latency", 32'(done_cyc - first_cyc), 52);
    chk("early beat count", 32'(beats.size()), 19);
    chk("early res_class", 32'(res_class), 3);
    chk("early res_value", res_value, 100);

    // Timeout, with a start pulse mid-stream that must not restart.
    mon_clear(); pulse_start();
    repeat (9) tick();
    start = 1; tick(); start = 0;
    wait_done(200);
    chk("timeout latency", 32'(done_cyc - first_cyc), 71);
    chk("timeout beat count", 32'(beats.size()), 19);
    chk("timeout flag", 32'(timeout), 1);
    chk("timeout res_class", 32'(res_class), 32'hF);
    chk("timeout res_value", res_value, 0);

    // Restart clears timeout; reset at pixel 5 drops out_valid at once.
    mon_clear(); pulse_start();
    chk("restart clears timeout", 32'(timeout), 0);
    repeat (15) tick();
    chk("pixel5 valid", 32'(out_valid), 1);
    chk("pixel5 data", 32'(out_data), 6);
    rst_n = 0; #1;
    chk("async reset valid", 32'(out_valid), 0);
    chk("async reset busy", 32'(busy), 0);
    tick(); tick();
    chk("reset res_class", 32'(res_class), 0);
    chk("reset res_value", res_value, 0);
    rst_n = 1;
    tick();

    // Restart from pixel 0; rewrite the last pixel while pixel 2 is in flight.
    mon_clear(); pulse_start();
    chk("restart valid", 32'(out_valid), 1);
    chk("restart pixel0", 32'(out_data), 1);
    repeat (6) tick();
    load(15, 8'hEE);
    wait_done(200);
    chk("rewrite pixel14", 32'(beats[14]), 15);
    chk("rewrite pixel15", 32'(beats[15]), 32'hEE);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
